// File: rtl/modular_adder_reg_pkg.sv
// Shared types for the registered modular adder: the action the result
// register takes on each rising edge.
package modular_adder_reg_pkg;

   typedef enum logic [1:0] {
      ACT_HOLD = 2'd0,
      ACT_LOAD = 2'd1,
      ACT_CLR  = 2'd2
   } reg_act_e;

   // Reset is handled in the flop itself; this resolves clear > enable > hold.
   function automatic reg_act_e sel_action(input logic clr, input logic en);
      if (clr)     return ACT_CLR;
      else if (en) return ACT_LOAD;
      else         return ACT_HOLD;
   endfunction

endpackage

// File: rtl/modular_adder_reg_core.sv
// Combinational modular add: one wide add, one conditional subtract of the
// modulus, then a select. Operands are assumed already reduced.
module mod_add_core #(
   parameter int BITWIDTH = 32
) (
   input  logic [BITWIDTH-1:0] a,
   input  logic [BITWIDTH-1:0] b,
   input  logic [BITWIDTH-1:0] mod,
   output logic [BITWIDTH-1:0] res
);

   logic [BITWIDTH:0] sum;
   logic [BITWIDTH:0] diff;
   logic              geq;
   logic              unused_diff_msb;

   // The carry bit of sum is kept so that a + b >= 2^BITWIDTH still compares
   // correctly against the modulus.
   assign sum  = {1'b0, a} + {1'b0, b};
   assign diff = sum - {1'b0, mod};
   assign geq  = (sum >= {1'b0, mod});
   assign res  = geq ? diff[BITWIDTH-1:0] : sum[BITWIDTH-1:0];

   assign unused_diff_msb = diff[BITWIDTH];

endmodule

// File: rtl/modular_adder_reg.sv
// Registered modular adder: oData <= (iData0 + iData1) mod iMod one cycle
// after an enabled edge, with reset > clear > enable priority on the register.
module modular_adder_reg
   import modular_adder_reg_pkg::*;
#(
   parameter int BITWIDTH = 32
) (
   input  logic                iClk,
   input  logic                iRst,
   input  logic                iEn,
   input  logic                iClr,
   input  logic [BITWIDTH-1:0] iData0,
   input  logic [BITWIDTH-1:0] iData1,
   input  logic [BITWIDTH-1:0] iMod,
   output logic [BITWIDTH-1:0] oData
);

   logic [BITWIDTH-1:0] mod_res;
   logic [BITWIDTH-1:0] data_d;
   logic [BITWIDTH-1:0] data_q;
   reg_act_e            act;

   mod_add_core #(
      .BITWIDTH (BITWIDTH)
   ) u_core (
      .a   (iData0),
      .b   (iData1),
      .mod (iMod),
      .res (mod_res)
   );

   always_comb begin
      data_d = data_q;
      act    = sel_action(iClr, iEn);
      case (act)
         ACT_CLR:  data_d = '0;
         ACT_LOAD: data_d = mod_res;
         default:  data_d = data_q;
      endcase
   end

   always_ff @(posedge iClk) begin
      if (iRst) data_q <= '0;
      else      data_q <= data_d;
   end

   assign oData = data_q;

endmodule

// File: tb/tb_modular_adder_reg.sv
// Self-checking bench for modular_adder_reg: directed corner cases plus a
// randomized stream against a plain-arithmetic reference.
module tb_modular_adder_reg;

   localparam int W = 32;

   logic         iClk = 1'b0;
   logic         iRst, iEn, iClr;
   logic [W-1:0] iData0, iData1, iMod;
   logic [W-1:0] oData;

   int checks = 0;
   int errors = 0;

   modular_adder_reg #(.BITWIDTH(W)) dut (
      .iClk   (iClk),
      .iRst   (iRst),
      .iEn    (iEn),
      .iClr   (iClr),
      .iData0 (iData0),
      .iData1 (iData1),
      .iMod   (iMod),
      .oData  (oData)
   );

   always #5 iClk = ~iClk;

   // Advance one rising edge and settle away from it before sampling.
   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   task automatic test_reset();
      iRst = 1'b1; iEn = 1'b1; iClr = 1'b0;
      iData0 = 32'd3; iData1 = 32'd4; iMod = 32'd23;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (oData !== 32'd0) begin
            errors++;
            $display("FAIL reset cyc%0d got %0d want 0", i, oData);
         end
      end
      iRst = 1'b0;
   endtask

   task automatic test_basic_wrap();
      logic [W-1:0] a_t [5] = '{32'd10, 32'd0, 32'd15, 32'd22, 32'd11};
      logic [W-1:0] b_t [5] = '{32'd12, 32'd0, 32'd20, 32'd22, 32'd12};
      logic [W-1:0] e_t [5] = '{32'd22, 32'd0, 32'd12, 32'd21, 32'd0};
      iMod = 32'd23; iEn = 1'b1; iClr = 1'b0;
      for (int i = 0; i < 5; i++) begin
         iData0 = a_t[i]; iData1 = b_t[i];
         tick();
         checks++;
         if (oData !== e_t[i]) begin
            errors++;
            $display("FAIL basic_wrap %0d+%0d got %0d want %0d", a_t[i], b_t[i], oData, e_t[i]);
         end
      end
   endtask

   task automatic test_carry_edges();
      // carry out, modulus zero (plain truncated sum), out-of-range operands
      logic [W-1:0] a_t [3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd30};
      logic [W-1:0] b_t [3] = '{32'hFFFF_FFFE, 32'd2,         32'd30};
      logic [W-1:0] m_t [3] = '{32'hFFFF_FFFF, 32'd0,         32'd23};
      logic [W-1:0] e_t [3] = '{32'hFFFF_FFFD, 32'd1,         32'd37};
      iEn = 1'b1; iClr = 1'b0;
      for (int i = 0; i < 3; i++) begin
         iData0 = a_t[i]; iData1 = b_t[i]; iMod = m_t[i];
         tick();
         checks++;
         if (oData !== e_t[i]) begin
            errors++;
            $display("FAIL carry_edges case%0d got %h want %h", i, oData, e_t[i]);
         end
      end
   endtask

   task automatic test_enable_hold();
      iMod = 32'd23; iEn = 1'b1; iClr = 1'b0;
      iData0 = 32'd5; iData1 = 32'd6;
      tick();
      checks++;
      if (oData !== 32'd11) begin
         errors++;
         $display("FAIL en_load got %0d want 11", oData);
      end
      iEn = 1'b0;
      for (int i = 0; i < 3; i++) begin
         iData0 = $urandom_range(22); iData1 = $urandom_range(22);
         tick();
         checks++;
         if (oData !== 32'd11) begin
            errors++;
            $display("FAIL en_hold cyc%0d got %0d want 11", i, oData);
         end
      end
   endtask

   task automatic test_clear();
      iMod = 32'd23; iEn = 1'b1; iClr = 1'b1;
      iData0 = 32'd4; iData1 = 32'd4;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (oData !== 32'd0) begin
            errors++;
            $display("FAIL clear cyc%0d got %0d want 0", i, oData);
         end
      end
      iClr = 1'b0; iData0 = 32'd1; iData1 = 32'd2;
      tick();
      checks++;
      if (oData !== 32'd3) begin
         errors++;
         $display("FAIL clear_release got %0d want 3", oData);
      end
   endtask

   task automatic test_reset_midstream();
      iMod = 32'd23; iEn = 1'b1; iClr = 1'b0;
      iData0 = 32'd7; iData1 = 32'd8;
      tick();
      checks++;
      if (oData !== 32'd15) begin
         errors++;
         $display("FAIL mid_pre got %0d want 15", oData);
      end
      iRst = 1'b1; iData0 = 32'd1; iData1 = 32'd1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (oData !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset cyc%0d got %0d want 0", i, oData);
         end
      end
      iRst = 1'b0; iData0 = 32'd2; iData1 = 32'd3;
      tick();
      checks++;
      if (oData !== 32'd5) begin
         errors++;
         $display("FAIL mid_resume got %0d want 5", oData);
      end
   endtask

   task automatic test_random();
      int unsigned a, b, expv;
      iMod = 32'd23; iClr = 1'b0; iEn = 1'b1;
      for (int i = 0; i < 100; i++) begin
         a = $urandom_range(22); b = $urandom_range(22);
         iData0 = a; iData1 = b;
         expv = (a + b) % 23;
         tick();
         checks++;
         if (oData !== expv) begin
            errors++;
            $display("FAIL random cyc%0d %0d+%0d got %0d want %0d", i, a, b, oData, expv);
         end
      end
   endtask

   task automatic test_random_enable();
      int unsigned a, b, model;
      logic en;
      model = oData;  // continues from a value already checked
      iMod = 32'd23; iClr = 1'b0;
      for (int i = 0; i < 60; i++) begin
         a = $urandom_range(22); b = $urandom_range(22);
         en = ($urandom_range(3) != 0);
         iData0 = a; iData1 = b; iEn = en;
         if (en) model = (a + b) % 23;
         tick();
         checks++;
         if (oData !== model) begin
            errors++;
            $display("FAIL rand_en cyc%0d en=%0b got %0d want %0d", i, en, oData, model);
         end
      end
   endtask

   initial begin
      iRst = 1'b1; iEn = 1'b0; iClr = 1'b0;
      iData0 = '0; iData1 = '0; iMod = 32'd23;
      test_reset();
      test_basic_wrap();
      test_carry_edges();
      test_enable_hold();
      test_clear();
      test_reset_midstream();
      test_random();
      test_random_enable();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
